// File: rtl/mpadder_serial_pkg.sv
// Shared parameters, state encoding and sizing helpers for the serial
// multi-precision adder/subtractor.
package mpadder_serial_pkg;

   localparam int unsigned N_DEF     = 514;
   localparam int unsigned CHUNK_DEF = 128;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Slices needed to hold the N+1-bit result: ceil((n+1)/chunk).
   function automatic int unsigned nchunk_of(input int unsigned n, input int unsigned chunk);
      return (n + chunk) / chunk;
   endfunction

   function automatic int unsigned cnt_width_of(input int unsigned nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/mp_chunk_add.sv
// One CHUNK-bit slice of the ripple adder: {cout,sum} = a + b + cin.
module mp_chunk_add
   import mpadder_serial_pkg::*;
#(
   parameter int unsigned CHUNK = CHUNK_DEF
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mpadder_serial.sv
// Serial multi-precision adder/subtractor: operands latched on start, one
// CHUNK-bit slice per cycle, result returned with a one-cycle done pulse.
module mpadder_serial
   import mpadder_serial_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned CHUNK = CHUNK_DEF
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic         subtract,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic [N:0]   result,
   output logic         done
);

   localparam int unsigned NCHUNK = nchunk_of(N, CHUNK);
   localparam int unsigned W      = NCHUNK * CHUNK;
   localparam int unsigned CW     = cnt_width_of(NCHUNK);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [W-1:0]    acc_q, acc_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N:0]      result_q, result_d;
   logic            done_q, done_d;

   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout;

   mp_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
      .a    (opa_q[CHUNK-1:0]),
      .b    (opb_q[CHUNK-1:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // NOTE: every _d gets a hold default before the case so no path leaves it
   // unassigned; otherwise this always_comb would infer latches.
   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               // Invert only the N operand bits; the zero-extension stays zero
               // so the top slice never produces a carry beyond bit N.
               opa_d   = {{(W-N){1'b0}}, in_a};
               opb_d   = {{(W-N){1'b0}}, (subtract ? ~in_b : in_b)};
               carry_d = subtract;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            opa_d   = opa_q >> CHUNK;
            opb_d   = opb_q >> CHUNK;
            acc_d   = {slice_sum, acc_q[W-1:CHUNK]};
            carry_d = slice_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               result_d = acc_d[N:0];
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mpadder_serial.sv
// Directed self-checking bench for mpadder_serial: latency, arithmetic
// boundaries, back-to-back starts, async reset abort and busy-input immunity.
module tb_mpadder_serial;

   localparam int N = 514;

   logic         clk;
   logic         resetn;
   logic         start;
   logic         subtract;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N:0]   result;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   mpadder_serial dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .subtract (subtract),
      .in_a     (in_a),
      .in_b     (in_b),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge (edge t); returns just after that edge.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      subtract = sub;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Observe done at each negedge; k-th negedge after edge t is what edge t+k samples.
   task automatic wait_done(input int k0, output int lat);
      lat = -1;
      for (int k = k0; k <= 20; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sub, input logic [N:0] exp);
      int lat;
      start_op(a, b, sub);
      wait_done(1, lat);
      check({tag, "_latency"}, (N+1)'(lat), (N+1)'(6));
      check({tag, "_result"}, result, exp);
      @(negedge clk);
      check({tag, "_done_width"}, {{N{1'b0}}, done}, '0);
      check({tag, "_result_hold"}, result, exp);
   endtask

   logic [N-1:0] all1;
   logic [N-1:0] lo128;
   logic [N:0]   exp_v;
   logic [N:0]   first_res;
   int           lat;
   int           pulses;
   int           pulse_at [3];
   int           late_done;

   initial begin
      all1     = '1;
      lo128    = '0;
      lo128[127:0] = '1;
      resetn   = 1'b0;
      start    = 1'b0;
      subtract = 1'b0;
      in_a     = '0;
      in_b     = '0;
      repeat (2) @(negedge clk);
      check("reset_done", {{N{1'b0}}, done}, '0);
      check("reset_result", result, '0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic add, latency 6
      run_op("add_1_1", 514'd1, 514'd1, 1'b0, 515'd2);

      // 2: carry ripples through every slice
      run_op("add_max_1", all1, 514'd1, 1'b0, {1'b1, 514'd0});
      exp_v = '0;
      exp_v[128] = 1'b1;
      run_op("add_slice_edge", lo128, 514'd1, 1'b0, exp_v);
      run_op("add_max_max", all1, all1, 1'b0, {1'b1, all1 - 514'd1});

      // 3: subtraction, no_borrow flag in result[N]
      run_op("sub_5_3", 514'd5, 514'd3, 1'b1, {1'b1, 514'd2});
      run_op("sub_3_5", 514'd3, 514'd5, 1'b1, {1'b0, all1 - 514'd1});
      run_op("sub_eq", 514'd9, 514'd9, 1'b1, {1'b1, 514'd0});
      run_op("sub_0_1", 514'd0, 514'd1, 1'b1, {1'b0, all1});

      // 4: start held high -> done every 7 cycles, 1 cycle wide
      @(negedge clk);
      in_a     = 514'd100;
      in_b     = 514'd23;
      subtract = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      pulses = 0;
      first_res = '0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (pulses < 3) pulse_at[pulses] = k;
            pulses++;
            check("held_result", result, 515'd123);
         end
      end
      start = 1'b0;
      check("held_pulse_count", (N+1)'(pulses), (N+1)'(3));
      check("held_pulse0", (N+1)'(pulse_at[0]), (N+1)'(6));
      check("held_pulse1", (N+1)'(pulse_at[1]), (N+1)'(13));
      check("held_pulse2", (N+1)'(pulse_at[2]), (N+1)'(20));
      repeat (3) @(negedge clk);

      // 5: reset mid-operation abandons it
      start_op(514'd1, 514'd1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("abort_done", {{N{1'b0}}, done}, '0);
      check("abort_result", result, '0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      late_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done === 1'b1) late_done++;
      end
      check("abort_no_late_done", (N+1)'(late_done), '0);
      run_op("after_reset_7_8", 514'd7, 514'd8, 1'b0, 515'd15);

      // 6: inputs changed while busy are ignored
      start_op(514'd10, 514'd4, 1'b0);
      @(negedge clk);
      in_a     = 514'd999;
      in_b     = 514'd555;
      subtract = 1'b1;
      start    = 1'b1;
      check("busy_no_done", {{N{1'b0}}, done}, '0);
      @(negedge clk);
      start    = 1'b0;
      wait_done(3, lat);
      check("busy_latency", (N+1)'(lat), (N+1)'(6));
      check("busy_result", result, 515'd14);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
